// File: rtl/noc_pkg.sv
// Shared NoC types, port numbering and the XY routing function.
package noc_pkg;

    typedef struct packed {
        logic        head;
        logic        tail;
        logic [3:0]  dst_x;
        logic [3:0]  dst_y;
        logic [31:0] payload;
    } flit_t;

    localparam int unsigned N_PORTS = 5;
    localparam int unsigned P_LOCAL = 0;
    localparam int unsigned P_NORTH = 1;
    localparam int unsigned P_EAST  = 2;
    localparam int unsigned P_SOUTH = 3;
    localparam int unsigned P_WEST  = 4;

    typedef logic [2:0] port_idx_t;

    typedef enum logic {
        LockFree,
        LockHeld
    } lock_state_e;

    // (p + k) mod N_PORTS
    function automatic port_idx_t port_add(input port_idx_t p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        return port_idx_t'(s % N_PORTS);
    endfunction

    // Dimension-ordered routing: X first, then Y (y grows southward).
    function automatic port_idx_t xy_route(input logic [3:0] dst_x, input logic [3:0] dst_y,
                                           input logic [3:0] x_loc, input logic [3:0] y_loc);
        if (dst_x > x_loc)      return port_idx_t'(P_EAST);
        else if (dst_x < x_loc) return port_idx_t'(P_WEST);
        else if (dst_y < y_loc) return port_idx_t'(P_NORTH);
        else if (dst_y > y_loc) return port_idx_t'(P_SOUTH);
        else                    return port_idx_t'(P_LOCAL);
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Generic synchronous flit FIFO; writes to a full FIFO are ignored.
module flit_fifo
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  wr_en_i,
    input  flit_t wr_data_i,
    input  logic  rd_en_i,
    output flit_t rd_data_o,
    output logic  empty_o,
    output logic  full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    flit_t          mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           push, pop;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign push      = wr_en_i & ~full_o;
    assign pop       = rd_en_i & ~empty_o;
    assign rd_data_o = mem_q[rptr_q];

    // Pointer and occupancy next state
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
        else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/rr_arbiter_lock.sv
// Round-robin arbiter for one output, holding a lock for the duration of a packet.
module rr_arbiter_lock
    import noc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PORTS-1:0] req_i,
    input  logic [N_PORTS-1:0] tails_i,
    output logic [N_PORTS-1:0] gnt_o
);

    lock_state_e state_q, state_d;
    port_idx_t   owner_q, owner_d;
    port_idx_t   ptr_q, ptr_d;
    logic        pick_vld;
    port_idx_t   pick;

    // First requester at or after the round-robin pointer
    always_comb begin
        pick_vld = 1'b0;
        pick     = ptr_q;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            if (!pick_vld && req_i[port_add(ptr_q, k)]) begin
                pick_vld = 1'b1;
                pick     = port_add(ptr_q, k);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LockFree;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: a winning tail (single-flit packet) never takes the lock
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            LockFree: begin
                if (pick_vld) begin
                    owner_d = pick;
                    ptr_d   = port_add(pick, 1);
                    state_d = tails_i[pick] ? LockFree : LockHeld;
                end
            end
            LockHeld: begin
                if (req_i[owner_q] && tails_i[owner_q]) state_d = LockFree;
            end
            default: state_d = LockFree;
        endcase
    end

    // Grant: owner only while locked, round-robin winner while free
    always_comb begin
        gnt_o = '0;
        unique case (state_q)
            LockFree: if (pick_vld) gnt_o[pick] = 1'b1;
            LockHeld: gnt_o[owner_q] = req_i[owner_q];
            default:  gnt_o = '0;
        endcase
    end

endmodule

// File: rtl/router_credit_wh.sv
// 5-port wormhole mesh router: input FIFOs, XY routing, locked RR allocation, credit flow control.
module router_credit_wh
    import noc_pkg::*;
#(
    parameter int unsigned X_LOC      = 0,
    parameter int unsigned Y_LOC      = 0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CREDITS    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  flit_t              i_flit     [N_PORTS],
    input  logic [N_PORTS-1:0] i_flit_val,
    output logic [N_PORTS-1:0] o_credit,
    output flit_t              o_flit     [N_PORTS],
    output logic [N_PORTS-1:0] o_flit_val,
    input  logic [N_PORTS-1:0] i_credit,
    output logic [N_PORTS-1:0] o_err
);

    localparam int unsigned CW = $clog2(CREDITS + 1);

    flit_t              head      [N_PORTS];
    logic [N_PORTS-1:0] empty, full, pop, sent, bad, want_vld, tails;
    port_idx_t          want      [N_PORTS];
    port_idx_t          route_q   [N_PORTS];
    port_idx_t          route_d   [N_PORTS];
    logic [N_PORTS-1:0] route_vld_q, route_vld_d;
    logic [N_PORTS-1:0] req       [N_PORTS];
    logic [N_PORTS-1:0] gnt       [N_PORTS];
    logic [N_PORTS-1:0] fire;
    flit_t              xbar      [N_PORTS];
    logic [CW-1:0]      cred_q    [N_PORTS];
    logic [CW-1:0]      cred_d    [N_PORTS];
    flit_t              o_flit_q  [N_PORTS];
    logic [N_PORTS-1:0] o_flit_val_q, o_credit_q, o_err_q, o_err_d;

    for (genvar g = 0; g < N_PORTS; g++) begin : g_port
        flit_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .wr_en_i   (i_flit_val[g]),
            .wr_data_i (i_flit[g]),
            .rd_en_i   (pop[g]),
            .rd_data_o (head[g]),
            .empty_o   (empty[g]),
            .full_o    (full[g])
        );

        rr_arbiter_lock u_arb (
            .clk     (clk),
            .reset   (reset),
            .req_i   (req[g]),
            .tails_i (tails),
            .gnt_o   (gnt[g])
        );
    end

    // Head flits route fresh; body/tail flits follow the latched route
    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            want[i]     = head[i].head ? xy_route(head[i].dst_x, head[i].dst_y,
                                                  4'(X_LOC), 4'(Y_LOC))
                                       : route_q[i];
            want_vld[i] = ~empty[i] & (head[i].head | route_vld_q[i]);
            bad[i]      = ~empty[i] & ~head[i].head & ~route_vld_q[i];
            tails[i]    = head[i].tail;
        end
    end

    // Requests are masked by credit so an allocation always traverses at once
    always_comb begin
        for (int unsigned o = 0; o < N_PORTS; o++) begin
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                req[o][i] = want_vld[i] & (want[i] == port_idx_t'(o)) & (cred_q[o] != '0);
            end
        end
    end

    // Crossbar and FIFO pops; malformed heads are popped and dropped
    always_comb begin
        sent = '0;
        for (int unsigned o = 0; o < N_PORTS; o++) begin
            fire[o] = |gnt[o];
            xbar[o] = '0;
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                if (gnt[o][i]) xbar[o] = head[i];
                sent[i] = sent[i] | gnt[o][i];
            end
        end
        pop = sent | bad;
    end

    // Route latch, credit counters and sticky error next state
    always_comb begin
        o_err_d = o_err_q | (i_flit_val & full) | bad;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            route_d[i]     = route_q[i];
            route_vld_d[i] = route_vld_q[i];
            if (sent[i]) begin
                if (head[i].tail) begin
                    route_vld_d[i] = 1'b0;
                end else if (head[i].head) begin
                    route_d[i]     = want[i];
                    route_vld_d[i] = 1'b1;
                end
            end
        end
        for (int unsigned o = 0; o < N_PORTS; o++) begin
            cred_d[o] = cred_q[o];
            if (fire[o] && !i_credit[o]) begin
                cred_d[o] = cred_q[o] - CW'(1);
            end else if (!fire[o] && i_credit[o] && cred_q[o] != CW'(CREDITS)) begin
                cred_d[o] = cred_q[o] + CW'(1);
            end
        end
    end

    // Per-port state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                route_q[p]  <= '0;
                cred_q[p]   <= CW'(CREDITS);
                o_flit_q[p] <= '0;
            end
            route_vld_q  <= '0;
            o_flit_val_q <= '0;
            o_credit_q   <= '0;
            o_err_q      <= '0;
        end else begin
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                route_q[p] <= route_d[p];
                cred_q[p]  <= cred_d[p];
                if (fire[p]) o_flit_q[p] <= xbar[p];
            end
            route_vld_q  <= route_vld_d;
            o_flit_val_q <= fire;
            o_credit_q   <= pop;
            o_err_q      <= o_err_d;
        end
    end

    assign o_flit     = o_flit_q;
    assign o_flit_val = o_flit_val_q;
    assign o_credit   = o_credit_q;
    assign o_err      = o_err_q;

endmodule

// File: tb/tb_router_credit_wh.sv
// Directed bench for router_credit_wh at node (1,1): CREDITS=4 instance and a CREDITS=2 instance.
module tb_router_credit_wh;
    import noc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    flit_t fi [N_PORTS];
    flit_t fo [N_PORTS];
    logic [4:0] fv, oc, ov, ic, oe;
    flit_t fi2 [N_PORTS];
    flit_t fo2 [N_PORTS];
    logic [4:0] fv2, oc2, ov2, ic2, oe2;

    int errors = 0;
    int checks = 0;

    router_credit_wh #(.X_LOC(1), .Y_LOC(1), .FIFO_DEPTH(4), .CREDITS(4)) dut (
        .clk(clk), .reset(reset), .i_flit(fi), .i_flit_val(fv), .o_credit(oc),
        .o_flit(fo), .o_flit_val(ov), .i_credit(ic), .o_err(oe)
    );

    router_credit_wh #(.X_LOC(1), .Y_LOC(1), .FIFO_DEPTH(4), .CREDITS(2)) dut2 (
        .clk(clk), .reset(reset), .i_flit(fi2), .i_flit_val(fv2), .o_credit(oc2),
        .o_flit(fo2), .o_flit_val(ov2), .i_credit(ic2), .o_err(oe2)
    );

    function automatic flit_t mk(input logic h, input logic t, input logic [3:0] dx,
                                 input logic [3:0] dy, input logic [31:0] pl);
        flit_t f;
        f.head = h; f.tail = t; f.dst_x = dx; f.dst_y = dy; f.payload = pl;
        return f;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        for (int p = 0; p < 5; p++) begin
            fi[p] = '0;
            fi2[p] = '0;
        end
        fv = '0; ic = '0; fv2 = '0; ic2 = '0;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        checks++; if (ov !== 5'b0) begin errors++; $display("FAIL rst_val: got %b want 00000", ov); end
        checks++; if (oc !== 5'b0) begin errors++; $display("FAIL rst_credit: got %b want 00000", oc); end
        checks++; if (oe !== 5'b0) begin errors++; $display("FAIL rst_err: got %b want 00000", oe); end
        checks++; if (ov2 !== 5'b0) begin errors++; $display("FAIL rst_val2: got %b want 00000", ov2); end
        for (int p = 0; p < 5; p++) begin
            checks++;
            if (fo[p] !== '0) begin
                errors++; $display("FAIL rst_flit%0d: got %h want 0", p, fo[p]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single;
        flit_t f;
        f = mk(1'b1, 1'b1, 4'd3, 4'd1, 32'h1111);
        fi[0] = f; fv[0] = 1'b1;
        step();
        fv = '0;
        checks++; if (ov !== 5'b0) begin errors++; $display("FAIL single_early: got %b want 00000", ov); end
        step();
        checks++; if (ov !== 5'b00100) begin errors++; $display("FAIL single_val: got %b want 00100", ov); end
        checks++; if (fo[2] !== f) begin errors++; $display("FAIL single_flit: got %h want %h", fo[2], f); end
        checks++; if (oc !== 5'b00001) begin errors++; $display("FAIL single_credit: got %b want 00001", oc); end
        step();
        checks++; if (ov !== 5'b0 || oc !== 5'b0) begin
            errors++; $display("FAIL single_after: got val %b credit %b want 0 0", ov, oc);
        end
    endtask

    task automatic test_wormhole;
        flit_t e;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                fi[4] = mk(c == 0, c == 3, 4'd1, 4'd0, 32'h200 + c);
                fv[4] = 1'b1;
            end else begin
                fv[4] = 1'b0;
            end
            step();
            if (c >= 1 && c <= 4) begin
                e = mk(c == 1, c == 4, 4'd1, 4'd0, 32'h200 + c - 1);
                checks++;
                if (ov !== 5'b00010 || fo[1] !== e) begin
                    errors++; $display("FAIL worm_c%0d: got %b %h want 00010 %h", c, ov, fo[1], e);
                end
            end
            if (c == 5) begin
                checks++; if (ov !== 5'b0) begin errors++; $display("FAIL worm_end: got %b want 0", ov); end
            end
        end
    endtask

    task automatic test_contention;
        flit_t a [3];
        flit_t s [3];
        flit_t b;
        flit_t exp_f [7];
        for (int k = 0; k < 3; k++) begin
            a[k] = mk(k == 0, k == 2, 4'd0, 4'd1, 32'hA0 + k);
            s[k] = mk(k == 0, k == 2, 4'd0, 4'd1, 32'h50 + k);
            exp_f[k] = a[k];
            exp_f[k+3] = s[k];
        end
        b = mk(1'b1, 1'b1, 4'd0, 4'd1, 32'hB0);
        exp_f[6] = b;
        for (int c = 0; c < 9; c++) begin
            ic[4] = 1'b1;
            fv = '0;
            if (c < 3) begin
                fi[0] = a[c]; fv[0] = 1'b1;
                fi[3] = s[c]; fv[3] = 1'b1;
            end else if (c == 3) begin
                fi[0] = b; fv[0] = 1'b1;
            end
            step();
            if (c >= 1 && c <= 7) begin
                checks++;
                if (ov[4] !== 1'b1 || fo[4] !== exp_f[c-1]) begin
                    errors++;
                    $display("FAIL rr_c%0d: got %b %h want 1 %h", c, ov[4], fo[4], exp_f[c-1]);
                end
            end
            if (c == 8) begin
                checks++; if (ov[4] !== 1'b0) begin errors++; $display("FAIL rr_end: got %b want 0", ov[4]); end
            end
        end
        ic = '0;
    endtask

    task automatic test_credit_stall;
        flit_t p [5];
        flit_t n;
        logic  exp_v [14];
        flit_t exp_f [14];
        for (int k = 0; k < 5; k++) p[k] = mk(k == 0, k == 4, 4'd3, 4'd1, 32'h400 + k);
        n = mk(1'b1, 1'b1, 4'd3, 4'd1, 32'h4EE);
        for (int c = 0; c < 14; c++) begin
            exp_v[c] = 1'b0;
            exp_f[c] = '0;
        end
        exp_v[1] = 1'b1;  exp_f[1] = p[0];
        exp_v[2] = 1'b1;  exp_f[2] = p[1];
        exp_v[6] = 1'b1;  exp_f[6] = p[2];
        exp_v[9] = 1'b1;  exp_f[9] = p[3];
        exp_v[10] = 1'b1; exp_f[10] = p[4];
        exp_v[12] = 1'b1; exp_f[12] = n;
        for (int c = 0; c < 14; c++) begin
            fv2 = '0;
            if (c < 5) begin fi2[0] = p[c]; fv2[0] = 1'b1; end
            if (c == 3) begin fi2[1] = n; fv2[1] = 1'b1; end
            ic2[2] = (c == 5 || c == 8 || c == 9 || c == 11);
            step();
            if (c >= 1) begin
                checks++;
                if (ov2[2] !== exp_v[c] || (exp_v[c] && fo2[2] !== exp_f[c])) begin
                    errors++;
                    $display("FAIL credit_c%0d: got %b %h want %b %h", c, ov2[2], fo2[2],
                             exp_v[c], exp_f[c]);
                end
            end
        end
        ic2 = '0;
        checks++; if (oe2 !== 5'b0) begin errors++; $display("FAIL credit_err: got %b want 0", oe2); end
    endtask

    // East output of dut2 is left at zero credits, so the east input cannot drain
    task automatic test_overflow;
        for (int c = 0; c < 5; c++) begin
            fi2[2] = mk(c == 0, c == 4, 4'd3, 4'd1, 32'h500 + c);
            fv2[2] = 1'b1;
            step();
            if (c == 3) begin
                checks++; if (oe2 !== 5'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", oe2); end
            end
        end
        fv2 = '0;
        checks++; if (oe2 !== 5'b00100) begin errors++; $display("FAIL ovf_set: got %b want 00100", oe2); end
        step();
        step();
        checks++; if (oe2 !== 5'b00100) begin errors++; $display("FAIL ovf_sticky: got %b want 00100", oe2); end
        checks++; if (ov2 !== 5'b0) begin errors++; $display("FAIL ovf_blocked: got %b want 0", ov2); end
        apply_reset();
        checks++; if (oe2 !== 5'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", oe2); end
    endtask

    task automatic test_malformed;
        fi[1] = mk(1'b0, 1'b0, 4'd3, 4'd1, 32'h77);
        fv[1] = 1'b1;
        step();
        fv = '0;
        checks++; if (oe !== 5'b0) begin errors++; $display("FAIL mal_early: got %b want 0", oe); end
        step();
        checks++; if (oe !== 5'b00010) begin errors++; $display("FAIL mal_err: got %b want 00010", oe); end
        checks++; if (oc !== 5'b00010) begin errors++; $display("FAIL mal_credit: got %b want 00010", oc); end
        checks++; if (ov !== 5'b0) begin errors++; $display("FAIL mal_val: got %b want 0", ov); end
    endtask

    task automatic test_reset_mid;
        flit_t f0;
        flit_t e;
        f0 = mk(1'b1, 1'b0, 4'd3, 4'd1, 32'h600);
        fi[0] = f0; fv[0] = 1'b1;
        step();
        fi[0] = mk(1'b0, 1'b0, 4'd3, 4'd1, 32'h601);
        step();
        checks++; if (ov !== 5'b00100 || fo[2] !== f0) begin
            errors++; $display("FAIL mid_first: got %b %h want 00100 %h", ov, fo[2], f0);
        end
        reset = 1'b1;
        fv = '0;
        step();
        reset = 1'b0;
        checks++; if (ov !== 5'b0 || oc !== 5'b0) begin
            errors++; $display("FAIL mid_rst: got val %b credit %b want 0 0", ov, oc);
        end
        checks++; if (fo[2] !== '0) begin errors++; $display("FAIL mid_flit: got %h want 0", fo[2]); end
        // Four back-to-back flits need the east counter back at CREDITS
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                fi[0] = mk(c == 0, c == 3, 4'd3, 4'd1, 32'h700 + c);
                fv[0] = 1'b1;
            end else begin
                fv[0] = 1'b0;
            end
            step();
            if (c >= 1 && c <= 4) begin
                e = mk(c == 1, c == 4, 4'd3, 4'd1, 32'h700 + c - 1);
                checks++;
                if (ov !== 5'b00100 || fo[2] !== e) begin
                    errors++; $display("FAIL mid_new_c%0d: got %b %h want 00100 %h", c, ov, fo[2], e);
                end
            end
            if (c == 5) begin
                checks++; if (ov !== 5'b0) begin errors++; $display("FAIL mid_end: got %b want 0", ov); end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        apply_reset();
        test_wormhole();
        apply_reset();
        test_contention();
        test_credit_stall();
        test_overflow();
        test_malformed();
        apply_reset();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
